// File: rtl/vx_dma_sched.sv
// vx_dma_sched: round-robin DMA descriptor arbiter into a registered bus slot,
// with completion-tag allocation and per-warp outstanding-transfer stall tracking.
module vx_dma_sched #(
  parameter int NUM_REQS  = 4,
  parameter int NUM_WARPS = 4,
  parameter int ADDR_W    = 32,
  parameter int LEN_W     = 16,
  parameter int NUM_TAGS  = 4,
  parameter int WID_W     = NUM_WARPS > 1 ? $clog2(NUM_WARPS) : 1,
  parameter int TAG_W     = NUM_TAGS > 1 ? $clog2(NUM_TAGS) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQS-1:0]        req_valid,
  input  logic [NUM_REQS*WID_W-1:0]  req_wid,
  input  logic [NUM_REQS*ADDR_W-1:0] req_src,
  input  logic [NUM_REQS*ADDR_W-1:0] req_dst,
  input  logic [NUM_REQS*LEN_W-1:0]  req_len,
  output logic [NUM_REQS-1:0]        req_ready,
  output logic                       bus_req_valid,
  output logic [ADDR_W-1:0]          bus_req_src,
  output logic [ADDR_W-1:0]          bus_req_dst,
  output logic [LEN_W-1:0]           bus_req_len,
  output logic [TAG_W-1:0]           bus_req_tag,
  input  logic                       bus_req_ready,
  input  logic                       bus_rsp_valid,
  input  logic [TAG_W-1:0]           bus_rsp_tag,
  output logic [NUM_WARPS-1:0]       warp_stall,
  output logic                       busy
);
  localparam int PW = NUM_REQS > 1 ? $clog2(NUM_REQS) : 1;
  localparam int CW = $clog2(NUM_TAGS + 1);
  logic [NUM_TAGS-1:0] tag_busy, busy_post, alloc_mask;
  logic [WID_W-1:0] tag_wid [NUM_TAGS];
  logic [CW-1:0] cnt [NUM_WARPS];
  logic [CW-1:0] cnt_nxt [NUM_WARPS];
  logic [PW-1:0] ptr, win, idx;
  logic found, rsp_hit, can_load, has_free, fire, load;
  logic [TAG_W-1:0] ftag;
  logic [WID_W-1:0] sel_wid;
  logic [ADDR_W-1:0] sel_src, sel_dst;
  logic [LEN_W-1:0] sel_len;
  // a tag freed this cycle is already visible to the allocator
  assign rsp_hit = bus_rsp_valid & tag_busy[bus_rsp_tag];
  assign busy_post = tag_busy & ~(rsp_hit ? (NUM_TAGS'(1) << bus_rsp_tag) : '0);
  assign has_free = ~&busy_post;
  assign can_load = ~bus_req_valid | bus_req_ready;
  always_comb begin
    found = 1'b0;
    win = '0;
    idx = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      idx = PW'((32'(ptr) + 32'(i)) % NUM_REQS);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win = idx;
      end
    end
  end
  always_comb begin
    sel_wid = '0;
    sel_src = '0;
    sel_dst = '0;
    sel_len = '0;
    for (int i = 0; i < NUM_REQS; i++)
      if (PW'(i) == win) begin
        sel_wid = req_wid[i*WID_W +: WID_W];
        sel_src = req_src[i*ADDR_W +: ADDR_W];
        sel_dst = req_dst[i*ADDR_W +: ADDR_W];
        sel_len = req_len[i*LEN_W +: LEN_W];
      end
  end
  always_comb begin
    ftag = '0;
    for (int i = NUM_TAGS - 1; i >= 0; i--)
      if (!busy_post[i]) ftag = TAG_W'(i);
  end
  assign fire = ~reset & found & can_load & has_free;
  assign req_ready = fire ? (NUM_REQS'(1) << win) : '0;
  // zero-length descriptors are consumed without touching slot, tags or counters
  assign load = fire & (sel_len != '0);
  assign alloc_mask = load ? (NUM_TAGS'(1) << ftag) : '0;
  assign busy = bus_req_valid | (|tag_busy);
  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++)
      cnt_nxt[w] = cnt[w] + CW'(load && sel_wid == WID_W'(w))
                 - CW'(rsp_hit && tag_wid[bus_rsp_tag] == WID_W'(w));
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_req_valid <= 1'b0;
      bus_req_src <= '0;
      bus_req_dst <= '0;
      bus_req_len <= '0;
      bus_req_tag <= '0;
      tag_busy <= '0;
      ptr <= '0;
      warp_stall <= '0;
      for (int t = 0; t < NUM_TAGS; t++) tag_wid[t] <= '0;
      for (int w = 0; w < NUM_WARPS; w++) cnt[w] <= '0;
    end else begin
      if (fire) ptr <= PW'((32'(win) + 1) % NUM_REQS);
      if (load) begin
        bus_req_valid <= 1'b1;
        bus_req_src <= sel_src;
        bus_req_dst <= sel_dst;
        bus_req_len <= sel_len;
        bus_req_tag <= ftag;
        tag_wid[ftag] <= sel_wid;
      end else if (bus_req_ready) begin
        bus_req_valid <= 1'b0;
      end
      tag_busy <= busy_post | alloc_mask;
      for (int w = 0; w < NUM_WARPS; w++) begin
        cnt[w] <= cnt_nxt[w];
        warp_stall[w] <= cnt_nxt[w] != '0;
      end
    end
  end
  a_ready_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(req_ready));
  a_hold: assert property (@(posedge clk) disable iff (reset) bus_req_valid && !bus_req_ready |=>
    bus_req_valid && $stable({bus_req_src, bus_req_dst, bus_req_len, bus_req_tag}));
  a_rsp_tag: assert property (@(posedge clk) disable iff (reset) bus_rsp_valid |-> tag_busy[bus_rsp_tag])
    else $warning("response on free tag %0d ignored", bus_rsp_tag);
endmodule

// File: tb/tb_vx_dma_sched.sv
// tb_vx_dma_sched: directed table/sequence checks plus random traffic against a tag-ownership model.
module tb_vx_dma_sched;
  logic clk = 1'b0, reset = 1'b1;
  logic [3:0] req_valid = '0, req_ready, warp_stall;
  logic [7:0] req_wid;
  logic [127:0] req_src, req_dst;
  logic [63:0] req_len;
  logic bus_req_valid, bus_req_ready = 1'b1, bus_rsp_valid = 1'b0, busy;
  logic [31:0] bus_req_src, bus_req_dst;
  logic [15:0] bus_req_len;
  logic [1:0] bus_req_tag, bus_rsp_tag = '0;
  logic [1:0] s_wid [4];
  logic [31:0] s_src [4], s_dst [4];
  logic [15:0] s_len [4];
  int nvec = 0, nerr = 0;
  int m_owner [4];
  int m_rr;
  bit m_v;
  logic [31:0] m_src, m_dst;
  logic [15:0] m_len;
  logic [1:0] m_tag;
  typedef struct {
    logic rsp_v;
    logic [1:0] rsp_tag;
    logic [3:0] exp_ready;
    logic [1:0] exp_tag;
    logic [3:0] exp_stall;
  } vec_t;
  vec_t tbl [9];

  vx_dma_sched dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_wid(req_wid), .req_src(req_src),
    .req_dst(req_dst), .req_len(req_len), .req_ready(req_ready), .bus_req_valid(bus_req_valid),
    .bus_req_src(bus_req_src), .bus_req_dst(bus_req_dst), .bus_req_len(bus_req_len),
    .bus_req_tag(bus_req_tag), .bus_req_ready(bus_req_ready), .bus_rsp_valid(bus_rsp_valid),
    .bus_rsp_tag(bus_rsp_tag), .warp_stall(warp_stall), .busy(busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      req_wid[i*2 +: 2] = s_wid[i];
      req_src[i*32 +: 32] = s_src[i];
      req_dst[i*32 +: 32] = s_dst[i];
      req_len[i*16 +: 16] = s_len[i];
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int t = 0; t < 4; t++) m_owner[t] = -1;
    m_rr = 0;
    m_v = 0;
  endtask

  task automatic req(input int i, input logic [1:0] w, input logic [31:0] s, input logic [31:0] d,
                     input logic [15:0] l);
    s_wid[i] = w;
    s_src[i] = s;
    s_dst[i] = d;
    s_len[i] = l;
  endtask

  task automatic idle();
    req_valid = '0;
    bus_rsp_valid = 1'b0;
    bus_req_ready = 1'b1;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, ".req_ready"}, req_ready, 0);
    chk({nm, ".bus_valid"}, bus_req_valid, 0);
    chk({nm, ".bus_src"}, bus_req_src, 0);
    chk({nm, ".bus_dst"}, bus_req_dst, 0);
    chk({nm, ".bus_len"}, bus_req_len, 0);
    chk({nm, ".bus_tag"}, bus_req_tag, 0);
    chk({nm, ".warp_stall"}, warp_stall, 0);
    chk({nm, ".busy"}, busy, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk_zero("reset");
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // entered at a negedge with inputs set: check against the model, then advance it
  task automatic cyc_a();
    int fr [4];
    int ft, win;
    bit can, g;
    logic [3:0] er, es;
    #1;
    for (int t = 0; t < 4; t++) fr[t] = m_owner[t];
    if (bus_rsp_valid && fr[bus_rsp_tag] >= 0) fr[bus_rsp_tag] = -1;
    ft = -1;
    for (int t = 3; t >= 0; t--) if (fr[t] < 0) ft = t;
    can = !m_v || bus_req_ready;
    win = -1;
    for (int k = 0; k < 4; k++) if (win < 0 && req_valid[(m_rr + k) % 4]) win = (m_rr + k) % 4;
    g = can && ft >= 0 && win >= 0;
    er = g ? 4'(1 << win) : 4'b0;
    es = '0;
    for (int t = 0; t < 4; t++) if (m_owner[t] >= 0) es[m_owner[t]] = 1'b1;
    chk("m.req_ready", req_ready, er);
    chk("m.bus_valid", bus_req_valid, m_v);
    if (m_v) chk("m.payload", {bus_req_src, bus_req_dst}, {m_src, m_dst});
    if (m_v) chk("m.len_tag", {bus_req_len, bus_req_tag}, {m_len, m_tag});
    chk("m.warp_stall", warp_stall, es);
    chk("m.busy", busy, m_v || es != 0);
    for (int t = 0; t < 4; t++) m_owner[t] = fr[t];
    if (g) m_rr = (win + 1) % 4;
    if (g && s_len[win] != 0) begin
      m_owner[ft] = s_wid[win];
      m_v = 1;
      m_src = s_src[win];
      m_dst = s_dst[win];
      m_len = s_len[win];
      m_tag = 2'(ft);
    end else if (bus_req_ready) m_v = 0;
  endtask

  task automatic cyc_b();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cyc();
    cyc_a();
    cyc_b();
  endtask

  initial begin
    tbl[0] = '{0, 0, 4'b0001, 0, 4'b0001};
    tbl[1] = '{0, 0, 4'b0010, 1, 4'b0011};
    tbl[2] = '{0, 0, 4'b0100, 2, 4'b0111};
    tbl[3] = '{0, 0, 4'b1000, 3, 4'b1111};
    tbl[4] = '{0, 0, 4'b0000, 0, 4'b1111};
    tbl[5] = '{0, 0, 4'b0000, 0, 4'b1111};
    tbl[6] = '{1, 2, 4'b0001, 2, 4'b1011};
    tbl[7] = '{0, 0, 4'b0000, 0, 4'b1011};
    tbl[8] = '{1, 0, 4'b0010, 0, 4'b1011};
    for (int i = 0; i < 4; i++) req(i, 2'(i), 32'h100 * i, 32'h8000 + i, 16'd16);
    req_valid = 4'hf;
    model_reset();
    do_reset();

    // single request
    idle();
    req(1, 2, 32'h1000, 32'h2000, 16'd64);
    req_valid = 4'b0010;
    cyc_a();
    chk("single.ready", req_ready, 4'b0010);
    cyc_b();
    chk("single.valid", bus_req_valid, 1);
    chk("single.tag", bus_req_tag, 0);
    chk("single.payload", {bus_req_src, bus_req_dst, bus_req_len}, {32'h1000, 32'h2000, 16'd64});
    chk("single.stall", warp_stall, 4'b0100);
    req_valid = '0;
    for (int c = 1; c < 5; c++) cyc();
    chk("single.stall_hold", warp_stall, 4'b0100);
    bus_rsp_valid = 1'b1;
    bus_rsp_tag = 0;
    cyc();
    chk("single.stall_fall", warp_stall, 0);
    chk("single.busy", busy, 0);

    // fairness and tag exhaustion
    do_reset();
    idle();
    for (int i = 0; i < 4; i++) req(i, 2'(i), 32'h100 * i, 32'h8000 + i, 16'd16);
    req_valid = 4'hf;
    foreach (tbl[i]) begin
      bus_rsp_valid = tbl[i].rsp_v;
      bus_rsp_tag = tbl[i].rsp_tag;
      cyc_a();
      chk($sformatf("fair%0d.ready", i), req_ready, tbl[i].exp_ready);
      cyc_b();
      if (tbl[i].exp_ready != 0) chk($sformatf("fair%0d.tag", i), bus_req_tag, tbl[i].exp_tag);
      chk($sformatf("fair%0d.stall", i), warp_stall, tbl[i].exp_stall);
    end

    // backpressure
    do_reset();
    idle();
    bus_req_ready = 1'b0;
    req(0, 0, 32'hAAAA0000, 32'hAAAA1000, 16'd32);
    req_valid = 4'b0001;
    cyc_a();
    chk("bp.first_ready", req_ready, 4'b0001);
    cyc_b();
    req(1, 3, 32'hBBBB0000, 32'hBBBB1000, 16'd48);
    req_valid = 4'b0010;
    for (int c = 0; c < 3; c++) begin
      cyc_a();
      chk("bp.ready_held", req_ready, 0);
      cyc_b();
      chk("bp.src_held", bus_req_src, 32'hAAAA0000);
      chk("bp.valid_held", bus_req_valid, 1);
    end
    bus_req_ready = 1'b1;
    cyc_a();
    chk("bp.release_ready", req_ready, 4'b0010);
    cyc_b();
    chk("bp.new_src", bus_req_src, 32'hBBBB0000);
    chk("bp.new_tag", bus_req_tag, 1);

    // same-warp overlap
    do_reset();
    idle();
    req(0, 1, 32'h10, 32'h20, 16'd8);
    req(2, 1, 32'h30, 32'h40, 16'd8);
    req_valid = 4'b0001;
    cyc();
    chk("ovl.tag0", bus_req_tag, 0);
    cyc();
    chk("ovl.tag1", bus_req_tag, 1);
    req_valid = '0;
    bus_rsp_valid = 1'b1;
    bus_rsp_tag = 0;
    cyc();
    chk("ovl.stall_after_rsp0", warp_stall, 4'b0010);
    bus_rsp_tag = 1;
    req_valid = 4'b0100;
    cyc_a();
    chk("ovl.regrant", req_ready, 4'b0100);
    cyc_b();
    chk("ovl.stall_kept", warp_stall, 4'b0010);
    chk("ovl.reuse_tag", bus_req_tag, 0);
    req_valid = '0;
    bus_rsp_tag = 0;
    cyc();
    chk("ovl.stall_fall", warp_stall, 0);

    // zero length and response on a free tag
    do_reset();
    idle();
    req(2, 0, 32'h50, 32'h60, 16'd0);
    req_valid = 4'b0100;
    cyc_a();
    chk("zl.ready", req_ready, 4'b0100);
    cyc_b();
    chk("zl.no_valid", bus_req_valid, 0);
    chk("zl.no_stall", warp_stall, 0);
    chk("zl.not_busy", busy, 0);
    req_valid = '0;
    bus_rsp_valid = 1'b1;
    bus_rsp_tag = 3;
    cyc();
    bus_rsp_valid = 1'b0;
    chk("bad.busy", busy, 0);
    chk("bad.stall", warp_stall, 0);
    req(0, 0, 32'h70, 32'h80, 16'd8);
    req(3, 3, 32'h90, 32'hA0, 16'd8);
    req_valid = 4'b1001;
    cyc_a();
    chk("zl.ptr_advanced", req_ready, 4'b1000);
    cyc_b();
    chk("zl.tag0", bus_req_tag, 0);

    // asynchronous reset mid-operation
    do_reset();
    idle();
    req(0, 0, 32'h100, 32'h200, 16'd4);
    req(1, 1, 32'h300, 32'h400, 16'd4);
    req(2, 2, 32'h500, 32'h600, 16'd4);
    req(3, 3, 32'h700, 32'h800, 16'd4);
    req_valid = 4'b0111;
    for (int c = 0; c < 3; c++) cyc();
    req_valid = '0;
    bus_req_ready = 1'b0;
    chk("mid.tag2", bus_req_tag, 2);
    chk("mid.stall", warp_stall, 4'b0111);
    #3;
    reset = 1'b1;
    #1;
    chk_zero("mid_reset");
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    bus_req_ready = 1'b1;
    req_valid = 4'hf;
    cyc_a();
    chk("post.grant0", req_ready, 4'b0001);
    cyc_b();
    chk("post.tag0", bus_req_tag, 0);

    // random traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      int busyt [$];
      req_valid = 4'($urandom);
      for (int i = 0; i < 4; i++)
        req(i, 2'($urandom), $urandom, $urandom, ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom));
      bus_req_ready = $urandom_range(0, 3) != 0;
      for (int t = 0; t < 4; t++) if (m_owner[t] >= 0) busyt.push_back(t);
      bus_rsp_valid = busyt.size() > 0 && $urandom_range(0, 2) != 0;
      bus_rsp_tag = busyt.size() > 0 ? 2'(busyt[$urandom_range(0, busyt.size() - 1)]) : 2'd0;
      cyc();
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/vx_dma_sched.md
Name: vx_dma_sched

Overview:
- Shares the core's single DMA bus among the SFU issue slices and tracks outstanding transfers per warp.
- Accepts DMA descriptors from each issue slice and round-robin arbitrates them into a one-entry registered output slot.
- Allocates a completion tag per transfer and drives a per-warp stall mask to the scheduler until every transfer owned by a warp has completed.
- Sits between the SFU DMA request path and the execute stage's DMA bus / warp-stall outputs.

Parameters:
- NUM_REQS, 4, number of requesting issue slices.
- NUM_WARPS, 4, warps per core; WID_W = max(1, clog2(NUM_WARPS)).
- ADDR_W, 32, source/destination address width.
- LEN_W, 16, transfer length width in bytes.
- NUM_TAGS, 4, maximum outstanding transfers; TAG_W = max(1, clog2(NUM_TAGS)).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQS  per-slice descriptor valid.
- req_wid  in  NUM_REQS*WID_W  issuing warp id.
- req_src  in  NUM_REQS*ADDR_W  source address.
- req_dst  in  NUM_REQS*ADDR_W  destination address.
- req_len  in  NUM_REQS*LEN_W  byte count.
- req_ready  out  NUM_REQS  per-slice accept (one-hot or zero).
- bus_req_valid  out  1  DMA bus request valid.
- bus_req_src  out  ADDR_W  source address to bus.
- bus_req_dst  out  ADDR_W  destination address to bus.
- bus_req_len  out  LEN_W  byte count to bus.
- bus_req_tag  out  TAG_W  completion tag.
- bus_req_ready  in  1  bus accepts request.
- bus_rsp_valid  in  1  transfer complete.
- bus_rsp_tag  in  TAG_W  tag of completed transfer.
- warp_stall  out  NUM_WARPS  warp has outstanding DMA.
- busy  out  1  any tag allocated or slot full.

Behaviour:
- Reset (asynchronous, active-high): slot empty, all tags free, per-warp counters 0, RR pointer 0. Outputs during and after reset: bus_req_valid=0, bus_req_src/dst/len/tag=0, req_ready=0, warp_stall=0, busy=0. Asserting reset mid-transfer discards all state; late responses after reset are ignored.
- Slot can_load = !slot_valid | (bus_req_valid & bus_req_ready). Loading requires can_load and at least one free tag.
- Arbitration (combinational):
  - Winner = first requester with req_valid set, searching from the RR pointer upward with wrap.
  - req_ready[winner] = can_load & free_tag_exists; all other req_ready bits are 0.
  - On handshake: load the slot with the descriptor and the lowest-index free tag, mark that tag busy, record the warp id in tag_wid[tag], increment cnt[wid], and set RR pointer = winner+1 mod NUM_REQS.
  - No handshake leaves the RR pointer unchanged.
- Zero-length descriptor (req_len==0): accepted normally (req_ready as above, pointer advances), but does not load the slot, allocate a tag, or touch counters.
- Slot: bus_req_valid = slot_valid, and the slot outputs are registered. Latency from req handshake to bus_req_valid is 1 cycle. Slot contents stay stable while valid & !ready. Back-to-back issue at 1 per cycle is sustained when bus_req_ready stays high.
- Completion: bus_rsp_valid with a busy tag frees that tag and decrements cnt[tag_wid[tag]].
  - A response on a free tag is ignored and trips a simulation assertion.
  - A freed tag may be reallocated in the same cycle.
- Simultaneous increment and decrement on the same warp: counter unchanged.
- Counter width clog2(NUM_TAGS+1); it cannot overflow because allocation requires a free tag.
- warp_stall[w] = (cnt[w] != 0), registered from the counter. It rises the cycle after the req handshake and falls the cycle after the last response for that warp.
- busy = slot_valid | (any tag busy).
- All tags busy: req_ready=0 for every slice; the slot may still drain. Freeing a tag enables acceptance the same cycle (the free-tag check uses the post-free vector).
- Assertions: req_ready is one-hot0; bus request payload is stable while valid & !ready.

Test Plan:
- Single request: slice1, wid=2, src=0x1000, dst=0x2000, len=64, bus_req_ready=1.
  - Expect bus_req_valid at cycle+1 with tag=0; warp_stall=4'b0100 from cycle+1.
  - Rsp tag=0 at cycle 5 → warp_stall=0 at cycle 6.
- Fairness: all 4 slices valid continuously, ready=1. Grants go 0,1,2,3,0…, with tags 0..3 allocated.
  - The 5th request stalls (req_ready=0) until a rsp arrives.
  - Rsp tag=2 with a simultaneous request → that request is granted the same cycle and reuses tag 2.
- Backpressure: bus_req_ready=0 for 3 cycles with a full slot. Payload is held stable, req_ready=0 for all slices, and the slot loads again on the cycle ready=1.
- Same-warp overlap: two wid=1 transfers (tags 0, 1).
  - Rsp tag 0 → warp_stall[1] stays 1; rsp tag 1 → warp_stall[1] falls.
  - A new wid=1 grant in the same cycle as rsp tag 1 → warp_stall[1] stays 1.
- Zero-length request and bad response:
  - len=0 → accepted, no bus_req_valid, warp_stall unchanged.
  - Rsp on a free tag 3 → state unchanged, assertion fires.
- Reset mid-operation: 3 tags busy, slot full, assert reset asynchronously → all outputs 0 immediately.
  - After release, a fresh request gets tag 0 and the grant starts from slice 0.
